mini_src_control_unit: RTL

- Hardwired Moore control unit that sequences the single-bus Mini SRC datapath through fetch and execute.
- Drives every datapath strobe: register in/out, PC, IR, MAR, MDR, Y, Z, HI and LO.
- Drives the ALU select and the Gra/Grb/Grc/Rin/Rout/BAout register-select inputs, which feed the datapath select-and-encode logic.
- Waits on a memory ready handshake for each read and write.

---
 rtl/mini_src_ctl_pkg.sv | 115 +++++++++++
 rtl/mini_src_control_unit_decode.sv | 90 +++++++++
 rtl/mini_src_control_unit.sv | 84 ++++++++
 3 files changed

// File: rtl/mini_src_ctl_pkg.sv
// Shared definitions for the Mini SRC control unit: opcodes, ALU selects,
// sequencer states, strobe bit map and small step-sequencing helpers.
package mini_src_ctl_pkg;

  localparam int CTL_W = 25;

  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_ROR  = 5'd7;
  localparam logic [4:0] OP_ROL  = 5'd8;
  localparam logic [4:0] OP_SHR  = 5'd9;
  localparam logic [4:0] OP_SHRA = 5'd10;
  localparam logic [4:0] OP_SHL  = 5'd11;
  localparam logic [4:0] OP_ADDI = 5'd12;
  localparam logic [4:0] OP_ANDI = 5'd13;
  localparam logic [4:0] OP_ORI  = 5'd14;
  localparam logic [4:0] OP_DIV  = 5'd15;
  localparam logic [4:0] OP_MUL  = 5'd16;
  localparam logic [4:0] OP_NEG  = 5'd17;
  localparam logic [4:0] OP_NOT  = 5'd18;
  localparam logic [4:0] OP_MFHI = 5'd24;
  localparam logic [4:0] OP_MFLO = 5'd25;
  localparam logic [4:0] OP_NOP  = 5'd26;
  localparam logic [4:0] OP_HALT = 5'd27;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
    ALU_SHR = 4'd4, ALU_SHRA = 4'd5, ALU_SHL = 4'd6, ALU_ROR = 4'd7,
    ALU_ROL = 4'd8, ALU_MUL = 4'd9, ALU_DIV = 4'd10, ALU_NEG = 4'd11,
    ALU_NOT = 4'd12
  } alu_e;

  typedef enum logic [3:0] {
    ST_RST, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
  } state_e;

  localparam int CTL_PCOUT    = 0;
  localparam int CTL_PCIN     = 1;
  localparam int CTL_INCPC    = 2;
  localparam int CTL_MARIN    = 3;
  localparam int CTL_MDRIN    = 4;
  localparam int CTL_MDROUT   = 5;
  localparam int CTL_MDRREAD  = 6;
  localparam int CTL_READ     = 7;
  localparam int CTL_WRITE    = 8;
  localparam int CTL_IRIN     = 9;
  localparam int CTL_YIN      = 10;
  localparam int CTL_ZIN      = 11;
  localparam int CTL_ZLOWOUT  = 12;
  localparam int CTL_ZHIGHOUT = 13;
  localparam int CTL_HIIN     = 14;
  localparam int CTL_HIOUT    = 15;
  localparam int CTL_LOIN     = 16;
  localparam int CTL_LOOUT    = 17;
  localparam int CTL_COUT     = 18;
  localparam int CTL_GRA      = 19;
  localparam int CTL_GRB      = 20;
  localparam int CTL_GRC      = 21;
  localparam int CTL_RIN      = 22;
  localparam int CTL_ROUT     = 23;
  localparam int CTL_BAOUT    = 24;

  function automatic logic [CTL_W-1:0] bit_of(input int idx);
    return {{(CTL_W-1){1'b0}}, 1'b1} << idx;
  endfunction

  function automatic alu_e op_alu(input logic [4:0] op);
    case (op)
      OP_SUB:           return ALU_SUB;
      OP_AND, OP_ANDI:  return ALU_AND;
      OP_OR, OP_ORI:    return ALU_OR;
      OP_SHR:           return ALU_SHR;
      OP_SHRA:          return ALU_SHRA;
      OP_SHL:           return ALU_SHL;
      OP_ROR:           return ALU_ROR;
      OP_ROL:           return ALU_ROL;
      OP_MUL:           return ALU_MUL;
      OP_DIV:           return ALU_DIV;
      OP_NEG:           return ALU_NEG;
      OP_NOT:           return ALU_NOT;
      default:          return ALU_ADD;
    endcase
  endfunction

  // Final execute step of each instruction; unknown opcodes end at T3 like nop.
  function automatic state_e last_step(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL,
      OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: return ST_T5;
      OP_NEG, OP_NOT:                   return ST_T4;
      OP_MUL, OP_DIV:                   return ST_T6;
      OP_LD, OP_ST:                     return ST_T7;
      default:                          return ST_T3;
    endcase
  endfunction

  function automatic state_e next_step(input state_e s);
    case (s)
      ST_T0:   return ST_T1;
      ST_T1:   return ST_T2;
      ST_T2:   return ST_T3;
      ST_T3:   return ST_T4;
      ST_T4:   return ST_T5;
      ST_T5:   return ST_T6;
      ST_T6:   return ST_T7;
      default: return ST_T0;
    endcase
  endfunction

endpackage

// File: rtl/mini_src_control_unit_decode.sv
// Purely combinational strobe decoder: (state, opcode) -> ctl, alu_sel, illegal.
module mini_src_control_unit_decode
  import mini_src_ctl_pkg::*;
(
  input  logic [3:0]       state_i,
  input  logic [4:0]       ir_op_i,
  output logic [CTL_W-1:0] ctl_o,
  output logic [3:0]       alu_sel_o,
  output logic             illegal_o
);

  state_e st;
  logic [CTL_W-1:0] z_to_ra;

  assign st      = state_e'(state_i);
  assign z_to_ra = bit_of(CTL_ZLOWOUT) | bit_of(CTL_GRA) | bit_of(CTL_RIN);

  always_comb begin
    ctl_o     = '0;
    alu_sel_o = ALU_ADD;
    illegal_o = 1'b0;
    case (st)
      ST_T0: ctl_o = bit_of(CTL_PCOUT) | bit_of(CTL_MARIN) | bit_of(CTL_INCPC) | bit_of(CTL_ZIN);
      ST_T1: ctl_o = bit_of(CTL_ZLOWOUT) | bit_of(CTL_PCIN) | bit_of(CTL_READ)
                   | bit_of(CTL_MDRIN) | bit_of(CTL_MDRREAD);
      ST_T2: ctl_o = bit_of(CTL_MDROUT) | bit_of(CTL_IRIN);
      ST_T3, ST_T4, ST_T5, ST_T6, ST_T7: begin
        case (ir_op_i)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL,
          OP_ADDI, OP_ANDI, OP_ORI: begin
            case (st)
              ST_T3: ctl_o = bit_of(CTL_GRB) | bit_of(CTL_ROUT) | bit_of(CTL_YIN);
              ST_T4: begin
                alu_sel_o = op_alu(ir_op_i);
                // Immediate forms take the second operand from the sign-extended C field.
                if (ir_op_i inside {OP_ADDI, OP_ANDI, OP_ORI})
                  ctl_o = bit_of(CTL_COUT) | bit_of(CTL_ZIN);
                else
                  ctl_o = bit_of(CTL_GRC) | bit_of(CTL_ROUT) | bit_of(CTL_ZIN);
              end
              ST_T5:   ctl_o = z_to_ra;
              default: ;
            endcase
          end
          OP_NEG, OP_NOT: begin
            if (st == ST_T3) begin
              ctl_o     = bit_of(CTL_GRB) | bit_of(CTL_ROUT) | bit_of(CTL_ZIN);
              alu_sel_o = op_alu(ir_op_i);
            end else if (st == ST_T4) begin
              ctl_o = z_to_ra;
            end
          end
          OP_MUL, OP_DIV: begin
            case (st)
              ST_T3: ctl_o = bit_of(CTL_GRA) | bit_of(CTL_ROUT) | bit_of(CTL_YIN);
              ST_T4: begin
                ctl_o     = bit_of(CTL_GRB) | bit_of(CTL_ROUT) | bit_of(CTL_ZIN);
                alu_sel_o = op_alu(ir_op_i);
              end
              ST_T5:   ctl_o = bit_of(CTL_ZLOWOUT) | bit_of(CTL_LOIN);
              ST_T6:   ctl_o = bit_of(CTL_ZHIGHOUT) | bit_of(CTL_HIIN);
              default: ;
            endcase
          end
          OP_LDI, OP_LD, OP_ST: begin
            case (st)
              ST_T3: ctl_o = bit_of(CTL_GRB) | bit_of(CTL_BAOUT) | bit_of(CTL_YIN);
              ST_T4: ctl_o = bit_of(CTL_COUT) | bit_of(CTL_ZIN);
              ST_T5: ctl_o = (ir_op_i == OP_LDI) ? z_to_ra
                                                 : (bit_of(CTL_ZLOWOUT) | bit_of(CTL_MARIN));
              ST_T6: ctl_o = (ir_op_i == OP_LD)
                           ? (bit_of(CTL_READ) | bit_of(CTL_MDRIN) | bit_of(CTL_MDRREAD))
                           : (bit_of(CTL_GRA) | bit_of(CTL_ROUT) | bit_of(CTL_MDRIN));
              ST_T7: ctl_o = (ir_op_i == OP_LD)
                           ? (bit_of(CTL_MDROUT) | bit_of(CTL_GRA) | bit_of(CTL_RIN))
                           : bit_of(CTL_WRITE);
              default: ;
            endcase
          end
          OP_MFHI: if (st == ST_T3) ctl_o = bit_of(CTL_HIOUT) | bit_of(CTL_GRA) | bit_of(CTL_RIN);
          OP_MFLO: if (st == ST_T3) ctl_o = bit_of(CTL_LOOUT) | bit_of(CTL_GRA) | bit_of(CTL_RIN);
          OP_NOP, OP_HALT: ;
          default: illegal_o = (st == ST_T3);
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mini_src_control_unit.sv
// Mini SRC hardwired control unit: state register, memory-wait handling and
// optional memory timeout (compile with MEM_TIMEOUT_EN to get the fault port).
module mini_src_control_unit
  import mini_src_ctl_pkg::*;
`ifdef MEM_TIMEOUT_EN
#(
  parameter int MEM_TIMEOUT = 16
)
`endif
(
  input  logic             clk,
  input  logic             clr,
  input  logic [4:0]       ir_op,
  input  logic             mem_rdy,
  output logic [CTL_W-1:0] ctl,
  output logic [3:0]       alu_sel,
  output logic             run,
  output logic             illegal
`ifdef MEM_TIMEOUT_EN
  ,
  output logic             fault
`endif
);

  state_e state_q, state_d;
  logic   stalled;

  mini_src_control_unit_decode u_decode (
    .state_i   (state_q),
    .ir_op_i   (ir_op),
    .ctl_o     (ctl),
    .alu_sel_o (alu_sel),
    .illegal_o (illegal)
  );

  // Read/Write are only ever asserted in the memory wait steps.
  assign stalled = (ctl[CTL_READ] | ctl[CTL_WRITE]) & ~mem_rdy;
  assign run     = (state_q != ST_RST) && (state_q != ST_HALT);

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          fault_q, fault_d;
  logic          timeout;

  assign timeout    = stalled && (wait_cnt_q == CW'(MEM_TIMEOUT - 1));
  assign wait_cnt_d = stalled ? wait_cnt_q + 1'b1 : '0;
  assign fault_d    = fault_q | timeout;
  assign fault      = fault_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wait_cnt_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      fault_q    <= fault_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RST:  state_d = ST_T0;
      ST_HALT: state_d = ST_HALT;
      default: begin
        if (state_q == ST_T3 && ir_op == OP_HALT) state_d = ST_HALT;
        else if (stalled)                         state_d = state_q;
        else if (state_q == last_step(ir_op))     state_d = ST_T0;
        else                                      state_d = next_step(state_q);
      end
    endcase
`ifdef MEM_TIMEOUT_EN
    if (timeout) state_d = ST_HALT;
`endif
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_q <= ST_RST;
    else      state_q <= state_d;
  end

endmodule
